// File: rtl/reg_file.sv
// Eight-entry (DEPTH-configurable) synchronous register file: single write port, registered read.
// Optional macro REG_FILE_BYPASS_EN makes a same-address write+read return the new data.
module reg_file #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 3,
    parameter int DEPTH  = 8
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic              WEN,
    input  logic              OEN,
    input  logic [ADDR_W-1:0] ADDR,
    input  logic [DATA_W-1:0] DIN,
    output logic [DATA_W-1:0] DOUT
);

    logic [DATA_W-1:0] REGS [DEPTH];
    logic [DATA_W-1:0] dout_q;
    logic [DATA_W-1:0] dout_d;
    logic [DATA_W-1:0] rd_data;
    logic              in_range;

    // Decode by comparison so DEPTH < 2**ADDR_W never indexes past the array.
    always_comb begin
        rd_data  = '0;
        in_range = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (ADDR == ADDR_W'(i)) begin
                rd_data  = REGS[i];
                in_range = 1'b1;
            end
        end
    end

    always_comb begin
        dout_d = dout_q;
        if (OEN) begin
`ifdef REG_FILE_BYPASS_EN
            if (WEN && in_range) begin
                dout_d = DIN;
            end else begin
                dout_d = rd_data;
            end
`else
            dout_d = rd_data;
`endif
        end
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            dout_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                REGS[i] <= '0;
            end
        end else begin
            dout_q <= dout_d;
            for (int i = 0; i < DEPTH; i++) begin
                if (WEN && (ADDR == ADDR_W'(i))) begin
                    REGS[i] <= DIN;
                end
            end
        end
    end

    assign DOUT = dout_q;

endmodule

// File: tb/tb_reg_file.sv
// Bench for reg_file: a full-depth instance and a DEPTH=6 instance driven in parallel,
// checked against an array model of the register-file rules.
module tb_reg_file;

    logic       clk;
    logic       rst_n;
    logic       wen;
    logic       oen;
    logic [2:0] addr;
    logic [7:0] din;
    logic [7:0] dout8;
    logic [7:0] dout6;

    int errors = 0;
    int checks = 0;

    // Model state: index 0 tracks the DEPTH=8 instance, index 1 the DEPTH=6 instance.
    logic [7:0] m     [2][8];
    logic [7:0] exp_d [2];
    int         dep   [2] = '{8, 6};

    reg_file #(.DATA_W(8), .ADDR_W(3), .DEPTH(8)) u8 (
        .CLK(clk), .RST_N(rst_n), .WEN(wen), .OEN(oen),
        .ADDR(addr), .DIN(din), .DOUT(dout8)
    );

    reg_file #(.DATA_W(8), .ADDR_W(3), .DEPTH(6)) u6 (
        .CLK(clk), .RST_N(rst_n), .WEN(wen), .OEN(oen),
        .ADDR(addr), .DIN(din), .DOUT(dout6)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic model_edge();
        bit hit;
        for (int k = 0; k < 2; k++) begin
            if (!rst_n) begin
                for (int j = 0; j < 8; j++) m[k][j] = 8'h00;
                exp_d[k] = 8'h00;
            end else begin
                hit = int'(addr) < dep[k];
                if (oen) begin
                    exp_d[k] = hit ? m[k][addr] : 8'h00;
`ifdef REG_FILE_BYPASS_EN
                    if (wen && hit) exp_d[k] = din;
`endif
                end
                if (wen && hit) m[k][addr] = din;
            end
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; wen = 1'b1; oen = 1'b1; addr = 3'd4; din = 8'hFF;
        cycle();
        cycle();
        checks++;
        if (dout8 !== 8'h00) begin
            errors++; $display("FAIL reset_dout8: got %h want 00", dout8);
        end
        checks++;
        if (dout6 !== 8'h00) begin
            errors++; $display("FAIL reset_dout6: got %h want 00", dout6);
        end
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (u8.REGS[i] !== 8'h00) begin
                errors++; $display("FAIL reset_regs[%0d]: got %h want 00", i, u8.REGS[i]);
            end
        end
        rst_n = 1'b1; wen = 1'b0; oen = 1'b0;
    endtask

    task automatic test_write_readback();
        logic [7:0] want;
        for (int i = 0; i < 8; i++) begin
            wen = 1'b1; oen = 1'b0; addr = 3'(i); din = 8'(8'h11 * (i + 1));
            cycle();
        end
        wen = 1'b0; oen = 1'b1;
        for (int i = 0; i < 8; i++) begin
            addr = 3'(i);
            cycle();
            want = 8'(8'h11 * (i + 1));
            checks++;
            if (dout8 !== want) begin
                errors++; $display("FAIL readback8[%0d]: got %h want %h", i, dout8, want);
            end
            want = (i < 6) ? 8'(8'h11 * (i + 1)) : 8'h00;
            checks++;
            if (dout6 !== want) begin
                errors++; $display("FAIL readback6[%0d]: got %h want %h", i, dout6, want);
            end
        end
    endtask

    task automatic test_hold();
        wen = 1'b0; oen = 1'b1; addr = 3'd3;
        cycle();
        oen = 1'b0; addr = 3'd5;
        cycle();
        cycle();
        checks++;
        if (dout8 !== 8'h44) begin
            errors++; $display("FAIL hold8: got %h want 44", dout8);
        end
        checks++;
        if (dout6 !== 8'h44) begin
            errors++; $display("FAIL hold6: got %h want 44", dout6);
        end
    endtask

    task automatic test_collision();
        logic [7:0] want;
`ifdef REG_FILE_BYPASS_EN
        want = 8'hA5;
`else
        want = 8'h33;
`endif
        wen = 1'b1; oen = 1'b1; addr = 3'd2; din = 8'hA5;
        cycle();
        checks++;
        if (dout8 !== want) begin
            errors++; $display("FAIL collision8: got %h want %h", dout8, want);
        end
        checks++;
        if (dout6 !== want) begin
            errors++; $display("FAIL collision6: got %h want %h", dout6, want);
        end
        wen = 1'b0;
        cycle();
        checks++;
        if (dout8 !== 8'hA5) begin
            errors++; $display("FAIL collision_next8: got %h want a5", dout8);
        end
        checks++;
        if (dout6 !== 8'hA5) begin
            errors++; $display("FAIL collision_next6: got %h want a5", dout6);
        end
    endtask

    task automatic test_out_of_range();
        wen = 1'b1; oen = 1'b0; addr = 3'd6; din = 8'h77;
        cycle();
        for (int i = 0; i < 6; i++) begin
            checks++;
            if (u6.REGS[i] !== m[1][i]) begin
                errors++; $display("FAIL oor_regs6[%0d]: got %h want %h", i, u6.REGS[i], m[1][i]);
            end
        end
        wen = 1'b0; oen = 1'b1;
        cycle();
        checks++;
        if (dout6 !== 8'h00) begin
            errors++; $display("FAIL oor_read6: got %h want 00", dout6);
        end
        checks++;
        if (dout8 !== 8'h77) begin
            errors++; $display("FAIL oor_read8: got %h want 77", dout8);
        end
    endtask

    task automatic test_mid_reset();
        wen = 1'b0; oen = 1'b1; addr = 3'd0;
        cycle();
        rst_n = 1'b0; wen = 1'b1; oen = 1'b1; addr = 3'd1; din = 8'h5A;
        cycle();
        rst_n = 1'b1; wen = 1'b0; oen = 1'b0;
        checks++;
        if (u8.REGS[1] !== 8'h00) begin
            errors++; $display("FAIL midreset_reg1: got %h want 00", u8.REGS[1]);
        end
        checks++;
        if (dout8 !== 8'h00) begin
            errors++; $display("FAIL midreset_dout8: got %h want 00", dout8);
        end
        checks++;
        if (dout6 !== 8'h00) begin
            errors++; $display("FAIL midreset_dout6: got %h want 00", dout6);
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 400; n++) begin
            rst_n = ($urandom_range(0, 39) != 0);
            wen   = 1'($urandom_range(0, 1));
            oen   = 1'($urandom_range(0, 1));
            addr  = 3'($urandom_range(0, 7));
            din   = 8'($urandom);
            cycle();
            checks++;
            if (dout8 !== exp_d[0]) begin
                errors++; $display("FAIL random8 n=%0d: got %h want %h", n, dout8, exp_d[0]);
            end
            checks++;
            if (dout6 !== exp_d[1]) begin
                errors++; $display("FAIL random6 n=%0d: got %h want %h", n, dout6, exp_d[1]);
            end
        end
        rst_n = 1'b1; wen = 1'b0; oen = 1'b0;
    endtask

    task automatic test_final_dump();
        cycle();
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (u8.REGS[i] !== m[0][i]) begin
                errors++; $display("FAIL dump8[%0d]: got %h want %h", i, u8.REGS[i], m[0][i]);
            end
        end
        for (int i = 0; i < 6; i++) begin
            checks++;
            if (u6.REGS[i] !== m[1][i]) begin
                errors++; $display("FAIL dump6[%0d]: got %h want %h", i, u6.REGS[i], m[1][i]);
            end
        end
    endtask

    initial begin
        rst_n = 1'b0; wen = 1'b0; oen = 1'b0; addr = '0; din = '0;
        for (int k = 0; k < 2; k++) begin
            for (int j = 0; j < 8; j++) m[k][j] = 8'h00;
            exp_d[k] = 8'h00;
        end
        test_reset();
        test_write_readback();
        test_hold();
        test_collision();
        test_out_of_range();
        test_mid_reset();
        test_random();
        test_final_dump();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
